// File: rtl/csi_pkg.sv
// Shared types and beat layout for the CSI extractor packet-detect path.
package csi_pkg;

    // One complex sample as carried on the AXIS beats: {Q, I}.
    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] i;
    } iq_t;

    // Width of one conjugate product or energy term.
    localparam int unsigned PROD_W = 33;

    // Input beat: {delayed, current}.
    localparam int unsigned IQ_W       = 32;
    localparam int unsigned IN_W       = 64;
    localparam int unsigned IN_CUR_LSB = 0;
    localparam int unsigned IN_DLY_LSB = 32;

    // Output beat: {energy, corr_im, corr_re}.
    localparam int unsigned OUT_W       = 96;
    localparam int unsigned OUT_FIELD_W = 32;
    localparam int unsigned OUT_RE_LSB  = 0;
    localparam int unsigned OUT_IM_LSB  = 32;
    localparam int unsigned OUT_E_LSB   = 64;

endpackage

// File: rtl/cmult_conj.sv
// Combinational c * conj(d) and |d|^2, all results PROD_W bits signed.
module cmult_conj
    import csi_pkg::*;
(
    input  iq_t                      cur,
    input  iq_t                      dly,
    output logic signed [PROD_W-1:0] p_re,
    output logic signed [PROD_W-1:0] p_im,
    output logic signed [PROD_W-1:0] p_e
);

    function automatic logic signed [31:0] ext32(input logic signed [15:0] x);
        return $signed({{16{x[15]}}, x});
    endfunction

    function automatic logic signed [PROD_W-1:0] ext33(input logic signed [31:0] x);
        return $signed({x[31], x});
    endfunction

    logic signed [31:0] m_ii, m_qq, m_qi, m_iq, m_di, m_dq;

    // Partial products; each fits 32 bits, the sums/differences need one more.
    always_comb begin
        m_ii = ext32(cur.i) * ext32(dly.i);
        m_qq = ext32(cur.q) * ext32(dly.q);
        m_qi = ext32(cur.q) * ext32(dly.i);
        m_iq = ext32(cur.i) * ext32(dly.q);
        m_di = ext32(dly.i) * ext32(dly.i);
        m_dq = ext32(dly.q) * ext32(dly.q);
        p_re = ext33(m_ii) + ext33(m_qq);
        p_im = ext33(m_qi) - ext33(m_iq);
        p_e  = ext33(m_di) + ext33(m_dq);
    end

endmodule

// File: rtl/delay_correlate.sv
// Sliding-window complex autocorrelator: moving sums of cur*conj(dly) and |dly|^2.
module delay_correlate
    import csi_pkg::*;
#(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned SHIFT  = 5
) (
    input  logic             s00_axis_aclk,
    input  logic             s00_axis_areset,
    input  logic             s00_axis_tvalid,
    input  logic [IN_W-1:0]  s00_axis_tdata,
    output logic             s00_axis_tready,
    output logic             m00_axis_tvalid,
    output logic [OUT_W-1:0] m00_axis_tdata,
    input  logic             m00_axis_tready
);

    localparam int unsigned PTR_W = $clog2(WINDOW);
    localparam int unsigned CNT_W = $clog2(WINDOW + 1);
    localparam int unsigned ACC_W = PROD_W + PTR_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - 31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - 31){1'b1}}, {31{1'b0}}};

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [PROD_W-1:0] x);
        return $signed({{PTR_W{x[PROD_W-1]}}, x});
    endfunction

    function automatic logic [OUT_FIELD_W-1:0] sat_out(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] sh;
        sh = s >>> SHIFT;
        if (sh > SAT_MAX) return 32'h7fff_ffff;
        if (sh < SAT_MIN) return 32'h8000_0000;
        return sh[OUT_FIELD_W-1:0];
    endfunction

    logic adv;
    iq_t  cur, dly;
    logic signed [PROD_W-1:0] p_re, p_im, p_e;

    // S1 registers
    logic                     s1_valid_q;
    logic signed [PROD_W-1:0] s1_re_q, s1_im_q, s1_e_q;

    // S2 window state
    logic signed [PROD_W-1:0] buf_re_q [WINDOW];
    logic signed [PROD_W-1:0] buf_im_q [WINDOW];
    logic signed [PROD_W-1:0] buf_e_q  [WINDOW];
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]         fill_q, fill_d;
    logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;
    logic signed [ACC_W-1:0]  acc_e_q, acc_e_d;
    logic                     out_valid_d;
    logic [OUT_W-1:0]         out_data_d;

    // Whole pipeline moves only when the output register is free or draining.
    assign adv             = m00_axis_tready || !m00_axis_tvalid;
    assign s00_axis_tready = adv;
    assign cur             = s00_axis_tdata[IN_CUR_LSB +: IQ_W];
    assign dly             = s00_axis_tdata[IN_DLY_LSB +: IQ_W];

    cmult_conj u_cmult_conj (
        .cur  (cur),
        .dly  (dly),
        .p_re (p_re),
        .p_im (p_im),
        .p_e  (p_e)
    );

    // S1: register products of each accepted beat.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            s1_valid_q <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_e_q     <= '0;
        end else if (adv) begin
            s1_valid_q <= s00_axis_tvalid;
            if (s00_axis_tvalid) begin
                s1_re_q <= p_re;
                s1_im_q <= p_im;
                s1_e_q  <= p_e;
            end
        end
    end

    // Next window state: add newest product, retire the one being overwritten.
    always_comb begin
        ptr_d      = ptr_q;
        fill_d     = fill_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;
        acc_e_d    = acc_e_q;
        out_data_d = '0;
        if (s1_valid_q) begin
            acc_re_d = acc_re_q + sext(s1_re_q) - sext(buf_re_q[ptr_q]);
            acc_im_d = acc_im_q + sext(s1_im_q) - sext(buf_im_q[ptr_q]);
            acc_e_d  = acc_e_q + sext(s1_e_q) - sext(buf_e_q[ptr_q]);
            ptr_d    = ptr_q + PTR_W'(1);
            if (fill_q != CNT_W'(WINDOW)) begin
                fill_d = fill_q + CNT_W'(1);
            end
        end
        out_valid_d = s1_valid_q && (fill_d == CNT_W'(WINDOW));
        out_data_d[OUT_RE_LSB +: OUT_FIELD_W] = sat_out(acc_re_d);
        out_data_d[OUT_IM_LSB +: OUT_FIELD_W] = sat_out(acc_im_d);
        out_data_d[OUT_E_LSB +: OUT_FIELD_W]  = sat_out(acc_e_d);
    end

    // S2: window buffer, accumulators, fill counter and output register.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            for (int unsigned k = 0; k < WINDOW; k++) begin
                buf_re_q[k] <= '0;
                buf_im_q[k] <= '0;
                buf_e_q[k]  <= '0;
            end
            ptr_q           <= '0;
            fill_q          <= '0;
            acc_re_q        <= '0;
            acc_im_q        <= '0;
            acc_e_q         <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
        end else if (adv) begin
            if (s1_valid_q) begin
                buf_re_q[ptr_q] <= s1_re_q;
                buf_im_q[ptr_q] <= s1_im_q;
                buf_e_q[ptr_q]  <= s1_e_q;
            end
            ptr_q           <= ptr_d;
            fill_q          <= fill_d;
            acc_re_q        <= acc_re_d;
            acc_im_q        <= acc_im_d;
            acc_e_q         <= acc_e_d;
            m00_axis_tvalid <= out_valid_d;
            if (out_valid_d) begin
                m00_axis_tdata <= out_data_d;
            end
        end
    end

endmodule

// File: tb/tb_delay_correlate.sv
// Self-checking bench for delay_correlate against a queue-based window model.
module tb_delay_correlate;

    localparam int WINDOW = 16;
    localparam int SHIFT  = 5;

    logic        clk = 1'b0;
    logic        areset;
    logic        s_tvalid;
    logic [63:0] s_tdata;
    logic        s_tready;
    logic        m_tvalid;
    logic [95:0] m_tdata;
    logic        m_tready;
    logic        s_tready_s0;
    logic        m_tvalid_s0;
    logic [95:0] m_tdata_s0;

    int n_cmp  = 0;
    int n_fail = 0;
    int bp_mode = 0;  // 0: ready high, 1: random, 2: ready low
    int out_count = 0;
    longint last_re, last_im, last_e;

    typedef struct {
        longint re;
        longint im;
        longint e;
    } trip_t;

    trip_t hist[$];
    trip_t exp_q[$];

    always #5 clk = ~clk;

    delay_correlate #(.WINDOW(WINDOW), .SHIFT(SHIFT)) u_dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (areset),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tready (s_tready),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tready (m_tready)
    );

    // Second instance with no shift, used to exercise saturation.
    delay_correlate #(.WINDOW(WINDOW), .SHIFT(0)) u_dut_s0 (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (areset),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tready (s_tready_s0),
        .m00_axis_tvalid (m_tvalid_s0),
        .m00_axis_tdata  (m_tdata_s0),
        .m00_axis_tready (m_tready)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic longint fld(input logic [95:0] d, input int lsb);
        logic [31:0] w;
        w = d[lsb +: 32];
        return longint'($signed(w));
    endfunction

    // Reference: keep the last WINDOW products, emit the shifted sums once full.
    task automatic model_push(input logic [63:0] d);
        longint ci, cq, di, dq;
        trip_t p, s;
        ci = longint'(shortint'(d[15:0]));
        cq = longint'(shortint'(d[31:16]));
        di = longint'(shortint'(d[47:32]));
        dq = longint'(shortint'(d[63:48]));
        p.re = ci * di + cq * dq;
        p.im = cq * di - ci * dq;
        p.e  = di * di + dq * dq;
        hist.push_back(p);
        if (hist.size() > WINDOW) void'(hist.pop_front());
        if (hist.size() == WINDOW) begin
            s.re = 0; s.im = 0; s.e = 0;
            foreach (hist[k]) begin
                s.re += hist[k].re;
                s.im += hist[k].im;
                s.e  += hist[k].e;
            end
            s.re = sat32(s.re >>> SHIFT);
            s.im = sat32(s.im >>> SHIFT);
            s.e  = sat32(s.e >>> SHIFT);
            exp_q.push_back(s);
        end
    endtask

    // Monitor: inputs are driven just after posedge, so the negedge view is
    // exactly what the next posedge will act on.
    initial begin
        logic        stall_held;
        logic [95:0] held;
        trip_t       x;
        stall_held = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                hist.delete();
                exp_q.delete();
                stall_held = 1'b0;
            end else begin
                if (stall_held) begin
                    chk("stall_tvalid_held", longint'(m_tvalid), 1);
                    chk("stall_tdata_stable", longint'(m_tdata == held), 1);
                end
                if (s_tvalid && s_tready) model_push(s_tdata);
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        chk("corr_re", fld(m_tdata, 0), x.re);
                        chk("corr_im", fld(m_tdata, 32), x.im);
                        chk("energy", fld(m_tdata, 64), x.e);
                    end
                    out_count++;
                    last_re = fld(m_tdata, 0);
                    last_im = fld(m_tdata, 32);
                    last_e  = fld(m_tdata, 64);
                end
                stall_held = m_tvalid && !m_tready;
                held = m_tdata;
            end
        end
    end

    // Downstream ready driver.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1:       m_tready = 1'($urandom_range(0, 1));
                2:       m_tready = 1'b0;
                default: m_tready = 1'b1;
            endcase
        end
    end

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        areset   = 1'b1;
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        areset = 1'b0;
    endtask

    task automatic send(input logic [15:0] ci, input logic [15:0] cq,
                        input logic [15:0] di, input logic [15:0] dq);
        int n;
        n = 0;
        s_tdata  = {dq, di, cq, ci};
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!s_tready) chk("tready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic [15:0] ci, input logic [15:0] cq,
                          input logic [15:0] di, input logic [15:0] dq);
        for (int k = 0; k < n; k++) send(ci, cq, di, dq);
    endtask

    task automatic drain(input string name);
        bp_mode = 0;
        idle(6);
        chk(name, longint'(exp_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int base;
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        last_re = 0; last_im = 0; last_e = 0;
        do_reset(3);

        // Reset state
        chk("reset_tvalid", longint'(m_tvalid), 0);
        chk("reset_tdata", longint'(m_tdata == '0), 1);
        chk("reset_tready", longint'(s_tready), 1);

        // Fill
        base = out_count;
        send_n(15, 16'd1000, 16'd0, 16'd1000, 16'd0);
        idle(4);
        chk("fill_no_early_out", out_count - base, 0);
        send(16'd1000, 16'd0, 16'd1000, 16'd0);
        idle(3);
        chk("fill_first_out", out_count - base, 1);
        chk("fill_re", last_re, 500000);
        chk("fill_im", last_im, 0);
        chk("fill_e", last_e, 500000);
        send_n(4, 16'd1000, 16'd0, 16'd1000, 16'd0);
        idle(3);
        chk("fill_steady_count", out_count - base, 5);
        chk("fill_steady_re", last_re, 500000);
        drain("fill_drain");

        // Rotation
        do_reset(1);
        send_n(16, 16'd0, 16'd1000, 16'd1000, 16'd0);
        idle(3);
        chk("rot_re", last_re, 0);
        chk("rot_im", last_im, 500000);
        chk("rot_e", last_e, 500000);
        drain("rot_drain");

        // Window slide
        do_reset(1);
        base = out_count;
        send_n(16, 16'd1000, 16'd0, 16'd1000, 16'd0);
        send_n(8, 16'd0, 16'd0, 16'd0, 16'd0);
        idle(3);
        chk("slide_count", out_count - base, 9);
        chk("slide_re", last_re, 250000);
        chk("slide_e", last_e, 250000);
        drain("slide_drain");

        // Extremes, plus saturation on the unshifted instance
        do_reset(1);
        send_n(16, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        idle(3);
        chk("ext_re", last_re, 64'sd1073741824);
        chk("ext_im", last_im, 0);
        chk("ext_e", last_e, 64'sd1073741824);
        chk("sat_pos_re", fld(m_tdata_s0, 0), 64'sd2147483647);
        chk("sat_pos_e", fld(m_tdata_s0, 64), 64'sd2147483647);
        send_n(16, 16'h8000, 16'd0, 16'd32767, 16'd0);
        idle(3);
        chk("ext_neg_re", last_re, -64'sd536854528);
        chk("ext_neg_e", last_e, 64'sd536838144);
        chk("sat_neg_re", fld(m_tdata_s0, 0), -64'sd2147483648);
        chk("sat_neg_e", fld(m_tdata_s0, 64), 64'sd2147483647);
        drain("ext_drain");

        // Backpressure with random data over a 64-beat ramp
        do_reset(1);
        base = out_count;
        bp_mode = 1;
        for (int k = 0; k < 64; k++) begin
            send(16'(k * 509 - 16000), 16'(16000 - k * 487),
                 16'($urandom), 16'($urandom));
        end
        drain("bp_drain");
        chk("bp_count", out_count - base, 64 - WINDOW + 1);

        // Reset while an output beat is stalled
        do_reset(1);
        send_n(15, 16'd1000, 16'd0, 16'd1000, 16'd0);
        bp_mode = 2;
        idle(2);
        send(16'd1000, 16'd0, 16'd1000, 16'd0);
        idle(3);
        chk("stalled_tvalid", longint'(m_tvalid), 1);
        do_reset(1);
        chk("rst_stall_tvalid", longint'(m_tvalid), 0);
        chk("rst_stall_tdata", longint'(m_tdata == '0), 1);
        bp_mode = 0;
        idle(2);

        // Reset mid-window
        base = out_count;
        send_n(10, 16'd1000, 16'd0, 16'd1000, 16'd0);
        do_reset(1);
        chk("midrst_tvalid", longint'(m_tvalid), 0);
        send_n(15, 16'd1000, 16'd0, 16'd1000, 16'd0);
        idle(4);
        chk("midrst_no_out", out_count - base, 0);
        send(16'd1000, 16'd0, 16'd1000, 16'd0);
        idle(3);
        chk("midrst_out", out_count - base, 1);
        chk("midrst_re", last_re, 500000);
        chk("midrst_e", last_e, 500000);
        drain("midrst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
